// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, state, ALU-select and RF-mux codes for proc_controller_p
package proc_pkg;

    // Opcodes; any value not listed executes as NOOP.
    localparam int unsigned OP_NOOP  = 0;
    localparam int unsigned OP_STORE = 1;
    localparam int unsigned OP_LOAD  = 2;
    localparam int unsigned OP_ADD   = 3;
    localparam int unsigned OP_SUB   = 4;
    localparam int unsigned OP_HALT  = 5;
    localparam int unsigned OP_LOADC = 6;
    localparam int unsigned OP_JMP   = 7;
    localparam int unsigned OP_JZ    = 8;

    // ALU select codes.
    localparam int unsigned ALU_PASS = 0;
    localparam int unsigned ALU_ADD  = 1;
    localparam int unsigned ALU_SUB  = 2;

    // Register-file write-data mux codes.
    localparam logic [1:0] RFS_ALU = 2'd0;
    localparam logic [1:0] RFS_MEM = 2'd1;
    localparam logic [1:0] RFS_IMM = 2'd2;

    // Controller states; the encoding is visible on the State port.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_LOADC  = 4'd10,
        ST_JMP    = 4'd11,
        ST_JZ     = 4'd12
    } state_e;

endpackage

// File: rtl/proc_field_decode.sv
// rtl/proc_field_decode.sv - combinational slicing of instruction fields
module proc_field_decode #(
    parameter int DA_W = 8,
    parameter int RA_W = 4,
    parameter int OP_W = 4
) (
    input  logic [OP_W+DA_W+RA_W-1:0] instruction,
    output logic [OP_W-1:0]           op,
    output logic [RA_W-1:0]           hi,
    output logic [RA_W-1:0]           rb,
    output logic [RA_W-1:0]           rc,
    output logic [DA_W-1:0]           d_hi,
    output logic [DA_W-1:0]           d_lo
);

    localparam int IW = OP_W + DA_W + RA_W;

    // d_hi overlaps hi and rb; it is the LOAD address, d_lo is the STORE/jump/immediate field.
    assign op   = instruction[IW-1 -: OP_W];
    assign hi   = instruction[DA_W+RA_W-1 -: RA_W];
    assign d_hi = instruction[DA_W+RA_W-1 -: DA_W];
    assign d_lo = instruction[DA_W-1:0];
    assign rb   = instruction[RA_W*2-1 -: RA_W];
    assign rc   = instruction[RA_W-1:0];

endmodule

// File: rtl/proc_controller_p.sv
// rtl/proc_controller_p.sv - parametrised Moore fetch/decode/execute controller
module proc_controller_p
    import proc_pkg::*;
#(
    parameter int DA_W   = 8,
    parameter int RA_W   = 4,
    parameter int OP_W   = 4,
    parameter int ALU_SW = 3,
    parameter int IW     = OP_W + DA_W + RA_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [IW-1:0]     instruction,
    input  logic              D_ready,
    input  logic              RF_Ra_zero,
    output logic [DA_W-1:0]   D_addr,
    output logic              D_wr,
    output logic              PC_clr,
    output logic              PC_up,
    output logic              PC_ld,
    output logic [DA_W-1:0]   PC_addr,
    output logic              IR_ld,
    output logic [1:0]        RF_s,
    output logic [DA_W-1:0]   RF_W_data,
    output logic [RA_W-1:0]   RF_W_addr,
    output logic              RF_W_wr,
    output logic [RA_W-1:0]   RF_Ra_addr,
    output logic              RF_Ra_rd,
    output logic [RA_W-1:0]   RF_Rb_addr,
    output logic              RF_Rb_rd,
    output logic [ALU_SW-1:0] Alu_s0,
    output logic [3:0]        State
);

    logic [OP_W-1:0] op;
    logic [RA_W-1:0] hi;
    logic [RA_W-1:0] rb;
    logic [RA_W-1:0] rc;
    logic [DA_W-1:0] d_hi;
    logic [DA_W-1:0] d_lo;

    state_e state_q;
    state_e state_d;
    state_e exec_state;

    proc_field_decode #(
        .DA_W (DA_W),
        .RA_W (RA_W),
        .OP_W (OP_W)
    ) u_field_decode (
        .instruction (instruction),
        .op          (op),
        .hi          (hi),
        .rb          (rb),
        .rc          (rc),
        .d_hi        (d_hi),
        .d_lo        (d_lo)
    );

    // Map the opcode to its execute state; unknown opcodes fall back to NOOP.
    always_comb begin
        exec_state = ST_NOOP;
        case (op)
            OP_W'(OP_STORE): exec_state = ST_STORE;
            OP_W'(OP_LOAD):  exec_state = ST_LOAD_A;
            OP_W'(OP_ADD):   exec_state = ST_ADD;
            OP_W'(OP_SUB):   exec_state = ST_SUB;
            OP_W'(OP_HALT):  exec_state = ST_HALT;
            OP_W'(OP_LOADC): exec_state = ST_LOADC;
            OP_W'(OP_JMP):   exec_state = ST_JMP;
            OP_W'(OP_JZ):    exec_state = ST_JZ;
            default:         exec_state = ST_NOOP;
        endcase
    end

    // Next-state logic; LOAD_A waits for memory, HALT waits for reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = exec_state;
            ST_LOAD_A: state_d = D_ready ? ST_LOAD_B : ST_LOAD_A;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register; reset is asynchronous so it aborts a stalled LOAD at once.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore outputs decoded from the current state and the held instruction.
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        PC_ld      = 1'b0;
        PC_addr    = '0;
        IR_ld      = 1'b0;
        RF_s       = RFS_ALU;
        RF_W_data  = '0;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Ra_addr = '0;
        RF_Ra_rd   = 1'b0;
        RF_Rb_addr = '0;
        RF_Rb_rd   = 1'b0;
        Alu_s0     = '0;
        case (state_q)
            ST_INIT: begin
                PC_clr = 1'b1;
            end
            ST_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            ST_STORE: begin
                D_addr     = d_lo;
                D_wr       = 1'b1;
                RF_Ra_addr = hi;
                RF_Ra_rd   = 1'b1;
            end
            ST_LOAD_A, ST_LOAD_B: begin
                D_addr    = d_hi;
                RF_s      = RFS_MEM;
                RF_W_addr = rc;
                RF_W_wr   = (state_q == ST_LOAD_B);
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = hi;
                RF_Ra_rd   = 1'b1;
                RF_Rb_addr = rb;
                RF_Rb_rd   = 1'b1;
                RF_W_addr  = rc;
                RF_W_wr    = 1'b1;
                Alu_s0     = (state_q == ST_ADD) ? ALU_SW'(ALU_ADD) : ALU_SW'(ALU_SUB);
            end
            ST_LOADC: begin
                RF_s      = RFS_IMM;
                RF_W_data = d_lo;
                RF_W_addr = hi;
                RF_W_wr   = 1'b1;
            end
            ST_JMP: begin
                PC_ld   = 1'b1;
                PC_addr = d_lo;
            end
            ST_JZ: begin
                RF_Ra_addr = hi;
                RF_Ra_rd   = 1'b1;
                PC_addr    = d_lo;
                PC_ld      = RF_Ra_zero;
            end
            default: begin
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_proc_controller_p.sv
// tb/tb_proc_controller_p.sv - randomized and directed self-checking bench for proc_controller_p
module tb_proc_controller_p;

    logic        clk;
    logic        Reset;
    logic [15:0] instruction;
    logic        D_ready;
    logic        RF_Ra_zero;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        PC_clr;
    logic        PC_up;
    logic        PC_ld;
    logic [7:0]  PC_addr;
    logic        IR_ld;
    logic [1:0]  RF_s;
    logic [7:0]  RF_W_data;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic        RF_Ra_rd;
    logic [3:0]  RF_Rb_addr;
    logic        RF_Rb_rd;
    logic [2:0]  Alu_s0;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_wr;
        logic       pc_clr;
        logic       pc_up;
        logic       pc_ld;
        logic [7:0] pc_addr;
        logic       ir_ld;
        logic [1:0] rf_s;
        logic [7:0] rf_w_data;
        logic [3:0] rf_w_addr;
        logic       rf_w_wr;
        logic [3:0] ra_addr;
        logic       ra_rd;
        logic [3:0] rb_addr;
        logic       rb_rd;
        logic [2:0] alu;
        logic [3:0] state;
    } outs_t;

    outs_t obs;
    assign obs = {D_addr, D_wr, PC_clr, PC_up, PC_ld, PC_addr, IR_ld, RF_s, RF_W_data,
                  RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0, State};

    proc_controller_p dut (
        .clk         (clk),
        .Reset       (Reset),
        .instruction (instruction),
        .D_ready     (D_ready),
        .RF_Ra_zero  (RF_Ra_zero),
        .D_addr      (D_addr),
        .D_wr        (D_wr),
        .PC_clr      (PC_clr),
        .PC_up       (PC_up),
        .PC_ld       (PC_ld),
        .PC_addr     (PC_addr),
        .IR_ld       (IR_ld),
        .RF_s        (RF_s),
        .RF_W_data   (RF_W_data),
        .RF_W_addr   (RF_W_addr),
        .RF_W_wr     (RF_W_wr),
        .RF_Ra_addr  (RF_Ra_addr),
        .RF_Ra_rd    (RF_Ra_rd),
        .RF_Rb_addr  (RF_Rb_addr),
        .RF_Rb_rd    (RF_Rb_rd),
        .Alu_s0      (Alu_s0),
        .State       (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    // Reference: which execute state the instruction table assigns to an opcode.
    function automatic int exec_of(input logic [3:0] op);
        case (op)
            4'd1:    return 4;
            4'd2:    return 5;
            4'd3:    return 7;
            4'd4:    return 8;
            4'd5:    return 9;
            4'd6:    return 10;
            4'd7:    return 11;
            4'd8:    return 12;
            default: return 3;
        endcase
    endfunction

    // Reference: expected output bundle for a state code, instruction and zero flag.
    function automatic outs_t model(input int st, input logic [15:0] ins, input logic z);
        outs_t o;
        logic [3:0] hi;
        logic [3:0] rb;
        logic [3:0] rc;
        logic [7:0] dlo;
        logic [7:0] dhi;
        hi  = ins[11:8];
        rb  = ins[7:4];
        rc  = ins[3:0];
        dlo = ins[7:0];
        dhi = ins[11:4];
        o = '0;
        o.state = 4'(st);
        if (st == 0) o.pc_clr = 1'b1;
        if (st == 1) begin o.ir_ld = 1'b1; o.pc_up = 1'b1; end
        if (st == 4) begin o.d_addr = dlo; o.d_wr = 1'b1; o.ra_addr = hi; o.ra_rd = 1'b1; end
        if (st == 5 || st == 6) begin
            o.d_addr = dhi; o.rf_s = 2'd1; o.rf_w_addr = rc; o.rf_w_wr = (st == 6);
        end
        if (st == 7 || st == 8) begin
            o.ra_addr = hi; o.ra_rd = 1'b1; o.rb_addr = rb; o.rb_rd = 1'b1;
            o.rf_w_addr = rc; o.rf_w_wr = 1'b1; o.alu = (st == 7) ? 3'd1 : 3'd2;
        end
        if (st == 10) begin o.rf_s = 2'd2; o.rf_w_data = dlo; o.rf_w_addr = hi; o.rf_w_wr = 1'b1; end
        if (st == 11) begin o.pc_ld = 1'b1; o.pc_addr = dlo; end
        if (st == 12) begin o.ra_addr = hi; o.ra_rd = 1'b1; o.pc_addr = dlo; o.pc_ld = z; end
        return o;
    endfunction

    // Advance to the next low phase, drive inputs, settle before sampling.
    task automatic cycle(input logic dr, input logic z);
        @(negedge clk);
        D_ready    = dr;
        RF_Ra_zero = z;
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        instruction = 16'h0000;
        D_ready = 1'b0;
        RF_Ra_zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== model(0, instruction, 1'b0))
            $display("FAIL reset_hold: got %h, want %h", obs, model(0, instruction, 1'b0));
        if (obs !== model(0, instruction, 1'b0)) errors++;
        @(negedge clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || PC_clr !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: State=%0d PC_clr=%b, want 0 1", State, PC_clr);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd1 || IR_ld !== 1'b1 || PC_up !== 1'b1 || PC_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: State=%0d IR_ld=%b PC_up=%b PC_clr=%b, want 1 1 1 0",
                     State, IR_ld, PC_up, PC_clr);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (obs !== model(2, instruction, 1'b0)) begin
            errors++;
            $display("FAIL reset_decode: got %h, want %h", obs, model(2, instruction, 1'b0));
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (obs !== model(3, instruction, 1'b0)) begin
            errors++;
            $display("FAIL reset_noop: got %h, want %h", obs, model(3, instruction, 1'b0));
        end
    endtask

    task automatic test_store;
        instruction = 16'h1505;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd4 || D_addr !== 8'h05 || D_wr !== 1'b1 || RF_Ra_addr !== 4'd5 ||
            RF_Ra_rd !== 1'b1 || RF_W_wr !== 1'b0) begin
            errors++;
            $display("FAIL store: State=%0d D_addr=%h D_wr=%b Ra=%0d Ra_rd=%b W_wr=%b, want 4 05 1 5 1 0",
                     State, D_addr, D_wr, RF_Ra_addr, RF_Ra_rd, RF_W_wr);
        end
    endtask

    task automatic test_load_stall;
        int in_load_a;
        instruction = 16'h2033;
        in_load_a = 0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle((k == 3), 1'b0);
            checks++;
            if (State !== 4'd5 || D_addr !== 8'h03 || RF_W_wr !== 1'b0 || RF_s !== 2'd1) begin
                errors++;
                $display("FAIL load_a[%0d]: State=%0d D_addr=%h W_wr=%b RF_s=%0d, want 5 03 0 1",
                         k, State, D_addr, RF_W_wr, RF_s);
            end else begin
                in_load_a++;
            end
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (State !== 4'd6 || RF_W_addr !== 4'd3 || RF_s !== 2'd1 || RF_W_wr !== 1'b1 ||
            D_addr !== 8'h03 || in_load_a != 4) begin
            errors++;
            $display("FAIL load_b: State=%0d W_addr=%0d RF_s=%0d W_wr=%b D_addr=%h load_a_cycles=%0d, want 6 3 1 1 03 4",
                     State, RF_W_addr, RF_s, RF_W_wr, D_addr, in_load_a);
        end
    endtask

    task automatic test_alu;
        instruction = 16'h3123;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd7 || RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd2 || RF_W_addr !== 4'd3 ||
            Alu_s0 !== 3'd1 || RF_W_wr !== 1'b1 || RF_Ra_rd !== 1'b1 || RF_Rb_rd !== 1'b1 || RF_s !== 2'd0) begin
            errors++;
            $display("FAIL add: got %h, want %h", obs, model(7, instruction, 1'b0));
        end
        instruction = 16'h4654;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd8 || Alu_s0 !== 3'd2 || RF_W_addr !== 4'd4 || RF_Ra_addr !== 4'd6 ||
            RF_Rb_addr !== 4'd5 || RF_W_wr !== 1'b1) begin
            errors++;
            $display("FAIL sub: got %h, want %h", obs, model(8, instruction, 1'b0));
        end
    endtask

    task automatic test_loadc;
        instruction = 16'h6A7F;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd10 || RF_s !== 2'd2 || RF_W_data !== 8'h7F || RF_W_addr !== 4'd10 ||
            RF_W_wr !== 1'b1) begin
            errors++;
            $display("FAIL loadc: State=%0d RF_s=%0d W_data=%h W_addr=%0d W_wr=%b, want 10 2 7f 10 1",
                     State, RF_s, RF_W_data, RF_W_addr, RF_W_wr);
        end
    endtask

    task automatic test_jumps;
        instruction = 16'h70C4;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd11 || PC_ld !== 1'b1 || PC_addr !== 8'hC4 || PC_up !== 1'b0) begin
            errors++;
            $display("FAIL jmp: State=%0d PC_ld=%b PC_addr=%h PC_up=%b, want 11 1 c4 0",
                     State, PC_ld, PC_addr, PC_up);
        end
        for (int z = 1; z >= 0; z--) begin
            instruction = 16'h8310;
            cycle(1'b0, 1'(z));
            cycle(1'b0, 1'(z));
            cycle(1'b0, 1'(z));
            checks++;
            if (State !== 4'd12 || PC_ld !== 1'(z) || PC_addr !== 8'h10 || RF_Ra_addr !== 4'd3 ||
                RF_Ra_rd !== 1'b1 || PC_up !== 1'b0) begin
                errors++;
                $display("FAIL jz_zero%0d: State=%0d PC_ld=%b PC_addr=%h Ra=%0d, want 12 %0d 10 3",
                         z, State, PC_ld, PC_addr, RF_Ra_addr, z);
            end
        end
    endtask

    task automatic test_random;
        int exp_states[$];
        logic [15:0] ins;
        logic [3:0] op;
        int stall;
        int pos;
        logic dr;
        logic z;
        outs_t exp;
        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            op = ins[15:12];
            if (op == 4'd5) begin
                op = 4'd2;
                ins[15:12] = op;
            end
            stall = $urandom_range(0, 3);
            exp_states.delete();
            exp_states.push_back(1);
            exp_states.push_back(2);
            if (exec_of(op) == 5) begin
                for (int k = 0; k <= stall; k++) exp_states.push_back(5);
                exp_states.push_back(6);
            end else begin
                exp_states.push_back(exec_of(op));
            end
            instruction = ins;
            pos = 0;
            foreach (exp_states[i]) begin
                if (exp_states[i] == 5) begin
                    dr = (pos == stall);
                    pos++;
                end else begin
                    dr = 1'($urandom);
                end
                z = 1'($urandom);
                cycle(dr, z);
                exp = model(exp_states[i], ins, z);
                checks++;
                if (obs !== exp || (PC_ld === 1'b1 && PC_up === 1'b1)) begin
                    errors++;
                    $display("FAIL random[%0d] ins=%h step=%0d: got %h, want %h", n, ins, i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_halt;
        logic z;
        instruction = 16'h5000;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            z = 1'($urandom);
            cycle(1'($urandom), z);
            checks++;
            if (obs !== model(9, instruction, z)) begin
                errors++;
                $display("FAIL halt[%0d]: got %h, want %h", k, obs, model(9, instruction, z));
            end
        end
    endtask

    task automatic test_reset_mid_load;
        @(negedge clk);
        Reset = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL reset_from_halt: State=%0d, want 0", State);
        end
        @(negedge clk);
        Reset = 1'b1;
        instruction = 16'h2A55;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd5) begin
            errors++;
            $display("FAIL mid_load_stall: State=%0d, want 5", State);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || PC_clr !== 1'b1 || D_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_load_reset: State=%0d PC_clr=%b D_addr=%h, want 0 1 00 before clock edge",
                     State, PC_clr, D_addr);
        end
        @(negedge clk);
        Reset = 1'b1;
        cycle(1'b0, 1'b0);
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL after_mid_load_reset: State=%0d, want 1", State);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_stall();
        test_alu();
        test_loadc();
        test_jumps();
        test_random();
        test_halt();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
